// File: rtl/dcache_pkg.sv
// dcache_pkg: geometry constants and FSM state encoding shared by the data cache.
package dcache_pkg;

    localparam int NUM_BLOCKS  = 8;
    localparam int BLOCK_BYTES = 4;
    localparam int ADDR_W      = 8;

    localparam int IDX_W   = $clog2(NUM_BLOCKS);
    localparam int OFF_W   = $clog2(BLOCK_BYTES);
    localparam int TAG_W   = ADDR_W - IDX_W - OFF_W;
    localparam int LINE_W  = 8 * BLOCK_BYTES;
    localparam int BADDR_W = ADDR_W - OFF_W;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE_BACK = 2'd1,
        MEM_FETCH  = 2'd2,
        UPDATE     = 2'd3
    } state_t;

endpackage

// File: rtl/dcache_if.sv
// dcache_if: CPU load/store path and block-wide memory bus seen by the cache.
// slave = the cache itself, master = the CPU plus data memory around it.
interface dcache_if;
    import dcache_pkg::*;

    logic                read;
    logic                write;
    logic [ADDR_W-1:0]   address;
    logic [7:0]          writedata;
    logic [7:0]          readdata;
    logic                busywait;

    logic                mem_read;
    logic                mem_write;
    logic [BADDR_W-1:0]  mem_address;
    logic [LINE_W-1:0]   mem_writedata;
    logic [LINE_W-1:0]   mem_readdata;
    logic                mem_busywait;

    modport master (
        output read, write, address, writedata, mem_readdata, mem_busywait,
        input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
    );

    modport slave (
        input  read, write, address, writedata, mem_readdata, mem_busywait,
        output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
    );

endinterface

// File: rtl/dcache_array.sv
// dcache_array: valid/dirty/tag/data storage. Only valid and dirty are
// cleared by reset; tag and data contents survive it.
module dcache_array
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [OFF_W-1:0]  wr_off,
    input  logic [7:0]        wr_byte,
    input  logic              fill_en,
    input  logic [IDX_W-1:0]  fill_idx,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [LINE_W-1:0] fill_data
);
    logic [NUM_BLOCKS-1:0] valid;
    logic [NUM_BLOCKS-1:0] dirty;
    logic [TAG_W-1:0]      tag_arr  [NUM_BLOCKS];
    logic [LINE_W-1:0]     data_arr [NUM_BLOCKS];

    assign rd_valid = valid[rd_idx];
    assign rd_dirty = dirty[rd_idx];
    assign rd_tag   = tag_arr[rd_idx];
    assign rd_data  = data_arr[rd_idx];

    // line status: a fill leaves the line clean, a store hit marks it dirty
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
            dirty <= '0;
        end else if (fill_en) begin
            valid[fill_idx] <= 1'b1;
            dirty[fill_idx] <= 1'b0;
        end else if (wr_en) begin
            dirty[wr_idx] <= 1'b1;
        end
    end

    // tag and data storage, deliberately not reset
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_arr[fill_idx]  <= fill_tag;
            data_arr[fill_idx] <= fill_data;
        end else if (wr_en) begin
            data_arr[wr_idx][{wr_off, 3'b000} +: 8] <= wr_byte;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
// Define DCACHE_STATS_EN to add saturating hit_count/miss_count outputs.
//
// state      | meaning
// IDLE       | serve hits with no stall; detect misses
// WRITE_BACK | dirty victim line being written to memory
// MEM_FETCH  | requested line being read from memory
// UPDATE     | fetched line written into the array; request replays as a hit
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    dcache_if.slave     bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);
    state_t            state;
    logic [TAG_W-1:0]  tag, miss_tag, rd_tag;
    logic [IDX_W-1:0]  idx, miss_idx, rd_idx;
    logic [OFF_W-1:0]  off;
    logic              rd_valid, rd_dirty;
    logic              req, hit, idle_hit;
    logic [LINE_W-1:0] rd_data, fill_buf;
    logic [7:0]        rd_hold;

    assign tag = bus.address[ADDR_W-1 -: TAG_W];
    assign idx = bus.address[OFF_W +: IDX_W];
    assign off = bus.address[OFF_W-1:0];

    // Miss handling works from the latched index/tag so a dropped request
    // cannot redirect a transfer that is already under way.
    assign rd_idx   = (state == IDLE) ? idx : miss_idx;
    assign req      = bus.read | bus.write;
    assign hit      = rd_valid && (rd_tag == tag);
    assign idle_hit = (state == IDLE) && hit;

    assign bus.busywait      = req && !idle_hit;
    assign bus.readdata      = idle_hit ? rd_data[{off, 3'b000} +: 8] : rd_hold;
    assign bus.mem_address   = (state == WRITE_BACK) ? {rd_tag, miss_idx} : {miss_tag, miss_idx};
    assign bus.mem_writedata = rd_data;

    dcache_array u_array (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (rd_idx),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_en     (idle_hit && bus.write),
        .wr_idx    (idx),
        .wr_off    (off),
        .wr_byte   (bus.writedata),
        .fill_en   (state == UPDATE),
        .fill_idx  (miss_idx),
        .fill_tag  (miss_tag),
        .fill_data (fill_buf)
    );

    // miss FSM with registered memory strobes; readdata holds its last value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            miss_tag      <= '0;
            miss_idx      <= '0;
            fill_buf      <= '0;
            rd_hold       <= '0;
        end else begin
            rd_hold <= bus.readdata;
            case (state)
                IDLE: begin
                    if (req && !hit) begin
                        miss_tag <= tag;
                        miss_idx <= idx;
                        if (rd_dirty) begin
                            state         <= WRITE_BACK;
                            bus.mem_write <= 1'b1;
                        end else begin
                            state        <= MEM_FETCH;
                            bus.mem_read <= 1'b1;
                        end
                    end
                end
                WRITE_BACK: begin
                    if (bus.mem_write && !bus.mem_busywait) begin
                        state         <= MEM_FETCH;
                        bus.mem_write <= 1'b0;
                        bus.mem_read  <= 1'b1;
                    end
                end
                MEM_FETCH: begin
                    if (bus.mem_read && !bus.mem_busywait) begin
                        state        <= UPDATE;
                        bus.mem_read <= 1'b0;
                        fill_buf     <= bus.mem_readdata;
                    end
                end
                UPDATE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    state_t prev_state;

    // saturating counters; the replay hit right after UPDATE is not a hit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_state <= IDLE;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            prev_state <= state;
            if (idle_hit && req && prev_state != UPDATE && hit_count != 16'hFFFF)
                hit_count <= hit_count + 16'd1;
            if (state == IDLE && req && !hit && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed stimulus with queued expectations; a negedge monitor
// compares each completed CPU access and each completed memory transfer.
// Memory model: each access is busy for 5 cycles; byte at address X holds X
// until written back.
module tb_dcache_ctrl;
    import dcache_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dcache_if bus();

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    dcache_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    logic [8:0]  cpu_q [$];   // {is_write, readdata}
    logic [38:0] mem_q [$];   // {is_write, block address, victim line}

    bit [31:0] wmem [64];
    bit [63:0] wvalid;
    int        mcnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [5:0] a);
        return {a, 2'd3, a, 2'd2, a, 2'd1, a, 2'd0};
    endfunction

    // memory model
    assign bus.mem_busywait = (bus.mem_read || bus.mem_write) && (mcnt != 4);
    assign bus.mem_readdata = wvalid[bus.mem_address] ? wmem[bus.mem_address] : pat(bus.mem_address);

    always @(posedge clk) begin
        if ((bus.mem_read || bus.mem_write) && mcnt != 4)
            mcnt <= mcnt + 1;
        else
            mcnt <= 0;
        if (bus.mem_write && mcnt == 4) begin
            wmem[bus.mem_address]   <= bus.mem_writedata;
            wvalid[bus.mem_address] <= 1'b1;
        end
    end

    // monitor
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if ((bus.read || bus.write) && !bus.busywait) begin
                chk("cpu_q_nonempty", cpu_q.size() != 0, 1);
                if (cpu_q.size() != 0)
                    chk("cpu_resp", {bus.write, (bus.write ? 8'h00 : bus.readdata)}, cpu_q.pop_front());
            end
            if ((bus.mem_read || bus.mem_write) && !bus.mem_busywait) begin
                chk("mem_excl", bus.mem_read & bus.mem_write, 0);
                chk("mem_q_nonempty", mem_q.size() != 0, 1);
                if (mem_q.size() != 0)
                    chk("mem_xfer", {bus.mem_write, bus.mem_address,
                                     (bus.mem_write ? bus.mem_writedata : 32'h0)}, mem_q.pop_front());
            end
        end
    end

    task automatic do_req(input bit wr, input logic [7:0] a, input logic [7:0] d, input int exp_stall);
        int stall = 0;
        bus.read      = !wr;
        bus.write     = wr;
        bus.address   = a;
        bus.writedata = d;
        forever begin
            @(negedge clk);
            if (!bus.busywait) break;
            stall++;
            if (stall > 100) break;
        end
        chk($sformatf("stall@%02h", a), stall, exp_stall);
        @(posedge clk);
        #1;
        bus.read  = 1'b0;
        bus.write = 1'b0;
    endtask

    task automatic cpu_rd(input logic [7:0] a, input logic [7:0] exp, input int exp_stall);
        cpu_q.push_back({1'b0, exp});
        do_req(1'b0, a, 8'h00, exp_stall);
    endtask

    task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d, input int exp_stall);
        cpu_q.push_back({1'b1, 8'h00});
        do_req(1'b1, a, d, exp_stall);
    endtask

    task automatic exp_mrd(input logic [5:0] ba);
        mem_q.push_back({1'b0, ba, 32'h0});
    endtask

    task automatic exp_mwr(input logic [5:0] ba, input logic [31:0] line);
        mem_q.push_back({1'b1, ba, line});
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.address   = 8'h00;
        bus.writedata = 8'h00;
        reset         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_read", bus.mem_read, 0);
        chk("rst_mem_write", bus.mem_write, 0);
        chk("rst_readdata", bus.readdata, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // cold miss, then hit on the freshly filled line
        exp_mrd(6'h01);
        cpu_rd(8'h05, 8'h05, 7);
        cpu_rd(8'h06, 8'h06, 0);

        // store hit, then conflicting load forces write-back of the dirty line
        cpu_wr(8'h05, 8'hAB, 0);
        exp_mwr(6'h01, 32'h0706AB04);
        exp_mrd(6'h09);
        cpu_rd(8'h25, 8'h25, 12);

        // the victim really reached memory
        exp_mrd(6'h01);
        cpu_rd(8'h05, 8'hAB, 7);

        // write-allocate on a clean miss, no write-back issued
        exp_mrd(6'h10);
        cpu_wr(8'h40, 8'h5A, 7);
        cpu_rd(8'h41, 8'h41, 0);
        exp_mwr(6'h10, 32'h4342415A);
        exp_mrd(6'h00);
        cpu_rd(8'h02, 8'h02, 12);

        // highest index
        exp_mrd(6'h07);
        cpu_rd(8'h1F, 8'h1F, 7);
        cpu_rd(8'h1C, 8'h1C, 0);

        // reset in the third MEM_FETCH cycle abandons the fill
        bus.read    = 1'b1;
        bus.address = 8'h0D;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_abort_mem_read", bus.mem_read, 1);
        reset = 1'b0;
        #1;
        chk("abort_mem_read", bus.mem_read, 0);
        chk("abort_mem_write", bus.mem_write, 0);
        chk("abort_readdata", bus.readdata, 0);
        chk("abort_busywait", bus.busywait, 1);
        bus.read = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_mrd(6'h03);
        cpu_rd(8'h0D, 8'h0D, 7);
        exp_mrd(6'h01);
        cpu_rd(8'h06, 8'h06, 7);

        // one miss followed by three hits
        pulse_reset();
        exp_mrd(6'h0C);
        cpu_rd(8'h30, 8'h30, 7);
        cpu_rd(8'h31, 8'h31, 0);
        cpu_rd(8'h32, 8'h32, 0);
        cpu_rd(8'h33, 8'h33, 0);
`ifdef DCACHE_STATS_EN
        chk("miss_count", miss_count, 16'd1);
        chk("hit_count", hit_count, 16'd3);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("cpu_q_left", cpu_q.size(), 0);
        chk("mem_q_left", mem_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
